mbyte_add_seq: RTL and testbench
================================

Name: mbyte_add_seq

Overview:
- Sequential multi-byte adder controller that sits directly upstream of, and consumes from, the team's 8-bit ripple-carry adder.
- Latches two NBYTES-wide operands and feeds them to an external 8-bit adder one byte per cycle, LSB byte first. It chains the adder's carry-out back as the next carry-in and assembles the full-width sum and final carry.
- Lets one small 8-bit adder perform 16/32/64-bit additions.

Parameters:
- NBYTES, 4, number of 8-bit bytes per operand; legal range is NBYTES >= 1.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request a new addition; sampled only in IDLE or DONE
- a_in  input  8*NBYTES  operand A, sampled on the accepted start
- b_in  input  8*NBYTES  operand B, sampled on the accepted start
- c_in  input  1  initial carry-in, sampled on the accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle completion pulse
- result  output  8*NBYTES  assembled sum
- cout  output  1  carry-out of the most significant byte
- fa_x  output  8  byte of A presented to the 8-bit adder
- fa_y  output  8  byte of B presented to the 8-bit adder
- fa_cin  output  1  carry presented to the 8-bit adder
- fa_sum  input  8  adder sum, combinational from fa_x/fa_y/fa_cin
- fa_cout  input  1  adder carry-out, combinational

Behaviour:
- Clocking and reset: one clock, clk. Asynchronous active-low reset, rst_n.
- While rst_n=0: state=IDLE, idx=0, carry register=0, operand registers=0, busy=0, done=0, result=0, cout=0.
- Reset asserted mid-operation aborts immediately, with no partial result retained.
- State IDLE:
  - fa_x=0, fa_y=0, fa_cin=0.
  - start=1 at an edge: latch a_in, b_in, c_in into the carry register; idx<=0; go to RUN.
- State RUN:
  - fa_x = A[8*idx +: 8], fa_y = B[8*idx +: 8], fa_cin = carry register.
  - At each edge: result[8*idx +: 8] <= fa_sum; carry <= fa_cout; idx <= idx+1.
  - On the edge that captures idx=NBYTES-1: cout <= fa_cout; go to DONE.
  - start is ignored. a_in/b_in/c_in changes have no effect.
- State DONE:
  - done=1 for exactly one cycle. fa_x/fa_y/fa_cin = 0.
  - start=1: accept exactly as in IDLE (back-to-back operation) and go to RUN.
  - Otherwise go to IDLE.
- Latency: start sampled at edge 0; bytes captured at edges 1..NBYTES.
  - busy=1 from edge 0 to edge NBYTES.
  - done=1 from edge NBYTES to edge NBYTES+1.
  - Throughput is one operation per NBYTES+1 cycles.
- Result validity:
  - result/cout are valid from done onward and held stable in IDLE/DONE until the next accepted start.
  - During RUN, result bytes update progressively and are not valid.
- Arithmetic: {cout, result} = A + B + c_in, modulo 2^(8*NBYTES+1). No saturation.
- idx width: clog2(NBYTES), minimum 1 bit.
- Boundary: NBYTES=1 gives a single RUN cycle. With NBYTES=1, an edge-0 start gives done in cycle 1 to 2.
- busy and done are never high simultaneously.

Optional Feature:
- Macro: MBYTE_ADD_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), the signed two's-complement overflow.
  - ovf = (A[MSB]==B[MSB]) && (fa_sum[7]!=A[MSB]), registered on the final RUN edge alongside cout.
  - ovf resets to 0 and is held with result.
- Not defined: port ovf and its logic are absent; all other behaviour is identical.

Test Plan:
- NBYTES=4, a=0x000000FF, b=0x00000001, c_in=0, start pulse:
  - fa_x sequence FF,00,00,00; fa_cin sequence 0,1,0,0.
  - result=0x00000100, cout=0; done exactly 4 edges after the start edge, busy high for those 4 cycles.
- a=0xFFFFFFFF, b=0x00000000, c_in=1:
  - result=0x00000000, cout=1, full carry ripple across all bytes.
  - With MBYTE_ADD_OVF_EN, ovf=0.
- Back-to-back:
  - First op 0x12345678+0x11111111, c_in=0 -> result 0x23456789, cout=0.
  - start held during the DONE cycle with 0x80000000+0x80000000 -> second op accepted with no IDLE cycle; result=0x00000000, cout=1, ovf=1 (if enabled).
- Ignore during RUN:
  - Assert start and change a_in/b_in to 0xDEADBEEF after the op begins.
  - Original operation completes unaltered and no second op starts.
  - done pulses once, then IDLE.
- Reset mid-RUN (idx=2):
  - busy/done/result/cout go to 0 asynchronously, before the next edge.
  - After release, 0x00000001+0x00000002 gives 0x00000003 with normal latency.
- Compile with NBYTES=1: 0xFF+0x01, c_in=0 -> result=0x00, cout=1, done one edge after the start edge.

Source files
------------

// File: rtl/mbyte_add_seq_if.sv
// Bus bundle between mbyte_add_seq and its requester / external 8-bit adder.
// Optional MBYTE_ADD_OVF_EN adds the signed-overflow flag ovf.
interface mbyte_add_seq_if #(
  parameter int NBYTES = 4
);
  logic                  start;
  logic [8*NBYTES-1:0]   a_in;
  logic [8*NBYTES-1:0]   b_in;
  logic                  c_in;
  logic                  busy;
  logic                  done;
  logic [8*NBYTES-1:0]   result;
  logic                  cout;
  logic [7:0]            fa_x;
  logic [7:0]            fa_y;
  logic                  fa_cin;
  logic [7:0]            fa_sum;
  logic                  fa_cout;
`ifdef MBYTE_ADD_OVF_EN
  logic                  ovf;

  modport slave (
    input  start, a_in, b_in, c_in, fa_sum, fa_cout,
    output busy, done, result, cout, fa_x, fa_y, fa_cin, ovf
  );
  modport master (
    output start, a_in, b_in, c_in, fa_sum, fa_cout,
    input  busy, done, result, cout, fa_x, fa_y, fa_cin, ovf
  );
`else
  modport slave (
    input  start, a_in, b_in, c_in, fa_sum, fa_cout,
    output busy, done, result, cout, fa_x, fa_y, fa_cin
  );
  modport master (
    output start, a_in, b_in, c_in, fa_sum, fa_cout,
    input  busy, done, result, cout, fa_x, fa_y, fa_cin
  );
`endif
endinterface

// File: rtl/mbyte_add_seq.sv
// Multi-byte adder controller driving an external 8-bit adder LSB byte first.
// Optional MBYTE_ADD_OVF_EN registers signed overflow alongside cout.
module mbyte_add_seq #(
  parameter int NBYTES = 4
) (
  input logic           clk,
  input logic           rst_n,
  mbyte_add_seq_if.slave bus
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q;
  logic           carry_q;
  logic [W-1:0]   a_q, b_q;
  logic [W-1:0]   result_q;
  logic           cout_q;
  logic           accept;
  logic           last;

  // start is honoured in IDLE and DONE alike, giving back-to-back operation
  assign accept = bus.start && (state_q != S_RUN);
  assign last   = (idx_q == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_RUN;
      S_RUN:   if (last)   state_d = S_DONE;
      S_DONE:  state_d = accept ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    bus.fa_x   = '0;
    bus.fa_y   = '0;
    bus.fa_cin = 1'b0;
    unique case (state_q)
      S_RUN: begin
        bus.busy   = 1'b1;
        bus.fa_x   = a_q[8*idx_q +: 8];
        bus.fa_y   = b_q[8*idx_q +: 8];
        bus.fa_cin = carry_q;
      end
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else if (state_q == S_RUN) begin
      result_q[8*idx_q +: 8] <= bus.fa_sum;
      carry_q                <= bus.fa_cout;
      idx_q                  <= idx_q + IW'(1);
      if (last) cout_q <= bus.fa_cout;
    end else if (accept) begin
      a_q     <= bus.a_in;
      b_q     <= bus.b_in;
      carry_q <= bus.c_in;
      idx_q   <= '0;
    end
  end

  assign bus.result = result_q;
  assign bus.cout   = cout_q;

`ifdef MBYTE_ADD_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state_q == S_RUN && last) begin
      ovf_q <= (a_q[W-1] == b_q[W-1]) && (bus.fa_sum[7] != a_q[W-1]);
    end
  end

  assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_mbyte_add_seq.sv
// Bench for mbyte_add_seq: arithmetic reference model plus directed and random stimulus.
// Also exercises a single-byte instance.
module tb_mbyte_add_seq;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mbyte_add_seq_if #(.NBYTES(N)) bus ();
  mbyte_add_seq_if #(.NBYTES(1)) bus1 ();

  mbyte_add_seq #(.NBYTES(N)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  mbyte_add_seq #(.NBYTES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // external 8-bit ripple-carry adders
  assign {bus.fa_cout,  bus.fa_sum}  = 9'(bus.fa_x)  + 9'(bus.fa_y)  + 9'(bus.fa_cin);
  assign {bus1.fa_cout, bus1.fa_sum} = 9'(bus1.fa_x) + 9'(bus1.fa_y) + 9'(bus1.fa_cin);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: operation in flight, byte index k, and expected sum
  bit          m_run = 0;
  bit          m_done = 0;
  int          m_k = 0;
  logic [63:0] m_A = '0, m_B = '0;
  bit          m_cin = 0;
  logic [63:0] m_sum = '0;  // full A+B+cin, bit 32 is the carry
  bit          m_ovf = 0;

  function automatic logic [7:0] byte_of(input logic [63:0] v, input int k);
    return 8'((v >> (8*k)) & 64'hFF);
  endfunction

  function automatic bit carry_into(input int k);
    logic [63:0] msk;
    msk = (64'd1 << (8*k)) - 64'd1;
    return 1'((((m_A & msk) + (m_B & msk) + 64'(m_cin)) >> (8*k)) & 64'd1);
  endfunction

  always @(negedge rst_n) begin
    m_run = 0; m_done = 0; m_k = 0; m_sum = '0; m_ovf = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (m_run) begin
        if (m_k == N - 1) begin
          m_run = 0; m_done = 1;
        end else begin
          m_k++;
        end
      end else begin
        m_done = 0;
        if (bus.start) begin
          m_A   = 64'(bus.a_in);
          m_B   = 64'(bus.b_in);
          m_cin = bus.c_in;
          m_sum = m_A + m_B + 64'(m_cin);
          m_ovf = (m_A[31] == m_B[31]) && (m_sum[31] != m_A[31]);
          m_run = 1; m_k = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 64'(bus.busy), 64'(m_run));
    chk("done", 64'(bus.done), 64'(m_done));
    if (m_run) begin
      chk("fa_x",   64'(bus.fa_x),   64'(byte_of(m_A, m_k)));
      chk("fa_y",   64'(bus.fa_y),   64'(byte_of(m_B, m_k)));
      chk("fa_cin", 64'(bus.fa_cin), 64'(carry_into(m_k)));
    end else begin
      chk("fa_idle", {bus.fa_x, bus.fa_y, 7'd0, bus.fa_cin}, 64'd0);
      chk("result", 64'(bus.result), m_sum & 64'hFFFF_FFFF);
      chk("cout",   64'(bus.cout),   64'(m_sum[32]));
`ifdef MBYTE_ADD_OVF_EN
      chk("ovf",    64'(bus.ovf),    64'(m_ovf));
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // issue one start, return number of edges after the start edge until done
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                        input bit keep_start, output int lat);
    bus.a_in = a; bus.b_in = b; bus.c_in = c; bus.start = 1'b1;
    cyc();
    if (!keep_start) bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 20) begin
      cyc();
      lat++;
    end
  endtask

  initial begin
    int lat;
    bus.start = 0; bus.a_in = '0; bus.b_in = '0; bus.c_in = 0;
    bus1.start = 0; bus1.a_in = '0; bus1.b_in = '0; bus1.c_in = 0;
    #1;
    chk("rst_busy",   64'(bus.busy),   64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_cout",   64'(bus.cout),   64'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, lat);
    chk("lat_ff01", 64'(lat), 64'd4);
    chk("res_ff01", 64'(bus.result), 64'h100);
    chk("cout_ff01", 64'(bus.cout), 64'd0);
    cyc();

    run_op(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, lat);
    chk("res_ripple", 64'(bus.result), 64'd0);
    chk("cout_ripple", 64'(bus.cout), 64'd1);
`ifdef MBYTE_ADD_OVF_EN
    chk("ovf_ripple", 64'(bus.ovf), 64'd0);
`endif
    cyc();

    // back-to-back: second start presented during the done cycle
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, lat);
    chk("res_b2b1", 64'(bus.result), 64'h2345_6789);
    chk("cout_b2b1", 64'(bus.cout), 64'd0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, lat);
    chk("lat_b2b2", 64'(lat), 64'd4);
    chk("res_b2b2", 64'(bus.result), 64'd0);
    chk("cout_b2b2", 64'(bus.cout), 64'd1);
`ifdef MBYTE_ADD_OVF_EN
    chk("ovf_b2b2", 64'(bus.ovf), 64'd1);
`endif
    cyc();
    chk("b2b_idle", 64'(bus.busy | bus.done), 64'd0);

    // start and operand changes during RUN are ignored
    bus.a_in = 32'h0102_0304; bus.b_in = 32'h1020_3040; bus.c_in = 0; bus.start = 1;
    cyc();
    bus.a_in = 32'hDEAD_BEEF; bus.b_in = 32'hDEAD_BEEF; bus.c_in = 1;
    cyc(); cyc();
    bus.start = 0;
    lat = 0;
    while (!bus.done && lat < 20) begin cyc(); lat++; end
    chk("res_ignore", 64'(bus.result), 64'h1122_3344);
    cyc();
    chk("ignore_idle", 64'(bus.busy | bus.done), 64'd0);

    // asynchronous reset while idx=2
    bus.a_in = 32'hFFFF_FFFF; bus.b_in = 32'h0000_0001; bus.c_in = 0; bus.start = 1;
    cyc();
    bus.start = 0;
    cyc(); cyc();
    rst_n = 1'b0;
    #1;
    chk("arst_busy",   64'(bus.busy),   64'd0);
    chk("arst_done",   64'(bus.done),   64'd0);
    chk("arst_result", 64'(bus.result), 64'd0);
    chk("arst_cout",   64'(bus.cout),   64'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    run_op(32'h1, 32'h2, 1'b0, 1'b0, lat);
    chk("lat_post_rst", 64'(lat), 64'd4);
    chk("res_post_rst", 64'(bus.result), 64'd3);
    cyc();

    // random cycle-level stimulus including corner operands
    for (int i = 0; i < 600; i++) begin
      bus.start = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0:       bus.a_in = 32'hFFFF_FFFF;
        1:       bus.a_in = 32'h8000_0000;
        default: bus.a_in = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       bus.b_in = 32'h0;
        1:       bus.b_in = 32'h7FFF_FFFF;
        default: bus.b_in = $urandom;
      endcase
      bus.c_in = 1'($urandom_range(0, 1));
      cyc();
    end
    bus.start = 0;
    for (int i = 0; i < 8; i++) cyc();

    // single-byte instance
    bus1.a_in = 8'hFF; bus1.b_in = 8'h01; bus1.c_in = 0; bus1.start = 1;
    cyc();
    bus1.start = 0;
    chk("n1_busy", 64'(bus1.busy), 64'd1);
    chk("n1_fa_x", 64'(bus1.fa_x), 64'hFF);
    cyc();
    chk("n1_done",   64'(bus1.done),   64'd1);
    chk("n1_busy2",  64'(bus1.busy),   64'd0);
    chk("n1_result", 64'(bus1.result), 64'd0);
    chk("n1_cout",   64'(bus1.cout),   64'd1);
    cyc();
    chk("n1_idle", 64'(bus1.done | bus1.busy), 64'd0);
    chk("n1_hold", 64'({bus1.cout, bus1.result}), 64'h100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
